bus_sequencer: RTL and testbench

- Parametrised successor to the CPU bus controller.
- Accepts one decoded instruction at a time over a valid/ready handshake and sequences the register-file, PC and RAM bus enables across one or more cycles.
- Supports a configurable register count and configurable RAM wait states, and adds byte stores, PC jumps, illegal-instruction detection and back-to-back issue.
- Sits between the instruction decoder and the register file / PC / RAM.

---
 rtl/bus_sequencer.sv | 113 +++++++++++
 tb/tb_bus_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: sequences register-file, PC and RAM bus enables for one decoded instruction at a time.
module bus_sequencer #(
    parameter int REG_COUNT = 8,
    parameter int REG_SEL_W = 3,
    parameter int RAM_WAIT  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [REG_SEL_W-1:0] reg_sel,
    input  logic                 op_alu_reg,
    input  logic                 op_alu_imm,
    input  logic                 op_cpy,
    input  logic                 op_cpypc,
    input  logic                 op_jmp,
    input  logic                 op_lb,
    input  logic                 op_sb,
    output logic                 reg_pc_write_en,
    output logic                 reg_pc_read_en,
    output logic [REG_COUNT-1:0] reg_out_en,
    output logic [REG_COUNT-1:0] reg_write_en,
    output logic                 ram_addr_en,
    output logic                 ram_out_en,
    output logic                 ram_write_en,
    output logic                 instruction_done,
    output logic                 illegal,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;
    localparam logic [REG_COUNT-1:0] R0 = REG_COUNT'(1);
    localparam logic [3:0] WAIT_INIT = RAM_WAIT == 0 ? 4'd0 : 4'(RAM_WAIT - 1);
    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [REG_COUNT-1:0]   sel_q_oh;
    logic                   lb_q;
    logic [6:0]             ops;
    logic [REG_COUNT-1:0]   sel_oh;
    logic                   uses_sel, bad, accept;
    assign ops         = {op_alu_reg, op_alu_imm, op_cpy, op_cpypc, op_jmp, op_lb, op_sb};
    assign sel_oh      = R0 << reg_sel;
    assign uses_sel    = op_alu_reg | op_cpy | op_cpypc | op_lb | op_sb;
    assign bad         = ops == 7'd0 || (ops & (ops - 7'd1)) != 7'd0 || (uses_sel && int'(reg_sel) >= REG_COUNT);
    assign instr_ready = state == IDLE || instruction_done;
    assign accept      = instr_valid && instr_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wait_cnt         <= 4'd0;
            sel_q_oh         <= '0;
            lb_q             <= 1'b0;
            reg_pc_write_en  <= 1'b0;
            reg_pc_read_en   <= 1'b0;
            reg_out_en       <= '0;
            reg_write_en     <= '0;
            ram_addr_en      <= 1'b0;
            ram_out_en       <= 1'b0;
            ram_write_en     <= 1'b0;
            instruction_done <= 1'b0;
            illegal          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            reg_pc_write_en  <= 1'b0;
            reg_pc_read_en   <= 1'b0;
            reg_out_en       <= '0;
            reg_write_en     <= '0;
            ram_addr_en      <= 1'b0;
            ram_out_en       <= 1'b0;
            ram_write_en     <= 1'b0;
            instruction_done <= 1'b0;
            illegal          <= 1'b0;
            busy             <= 1'b0;
            // Outputs are registered, so each branch drives the strobes of the state being entered.
            if (state == ADDR && RAM_WAIT != 0) begin
                state    <= WAIT;
                wait_cnt <= WAIT_INIT;
                busy     <= 1'b1;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
                busy     <= 1'b1;
            end else if (state == ADDR || state == WAIT) begin
                state            <= DATA;
                busy             <= 1'b1;
                instruction_done <= 1'b1;
                ram_out_en       <= lb_q;
                reg_write_en     <= lb_q ? sel_q_oh : '0;
                reg_out_en       <= lb_q ? '0 : sel_q_oh;
                ram_write_en     <= !lb_q;
            end else begin
                state <= IDLE;
                if (accept) begin
                    sel_q_oh <= sel_oh;
                    lb_q     <= op_lb;
                    if (bad) begin
                        illegal          <= 1'b1;
                        instruction_done <= 1'b1;
                    end else if (op_lb || op_sb) begin
                        state       <= ADDR;
                        reg_out_en  <= R0;
                        ram_addr_en <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        instruction_done <= 1'b1;
                        reg_out_en       <= op_alu_reg ? sel_oh : (op_cpy || op_jmp) ? R0 : '0;
                        reg_write_en     <= (op_alu_reg || op_alu_imm) ? R0 : (op_cpy || op_cpypc) ? sel_oh : '0;
                        reg_pc_read_en   <= op_cpypc;
                        reg_pc_write_en  <= op_jmp;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed checks of three bus_sequencer configurations sharing one stimulus bus.
module tb_bus_sequencer;
    localparam logic [6:0] ADD = 7'b1000000, IMM = 7'b0100000, CPY = 7'b0010000, CPC = 7'b0001000;
    localparam logic [6:0] JMP = 7'b0000100, LB = 7'b0000010, SB = 7'b0000001, NOP = 7'b0000000;
    logic clk = 1'b0, rst_n = 1'b0;
    logic v0 = 1'b0, v2 = 1'b0, v6 = 1'b0;
    logic [2:0] reg_sel = 3'd0;
    logic [6:0] ops = NOP;
    int checks = 0, errors = 0;
    logic rdy0, pcw0, pcr0, ae0, ro0, rw0, dn0, il0, bz0;
    logic rdy2, pcw2, pcr2, ae2, ro2, rw2, dn2, il2, bz2;
    logic rdy6, pcw6, pcr6, ae6, ro6, rw6, dn6, il6, bz6;
    logic [7:0] out0, wr0, out2, wr2;
    logic [5:0] out6, wr6;
    logic [24:0] snap0, snap2, snap6;
    always #5 clk = ~clk;
    bus_sequencer #(.REG_COUNT(8), .REG_SEL_W(3), .RAM_WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v0), .instr_ready(rdy0), .reg_sel(reg_sel),
        .op_alu_reg(ops[6]), .op_alu_imm(ops[5]), .op_cpy(ops[4]), .op_cpypc(ops[3]),
        .op_jmp(ops[2]), .op_lb(ops[1]), .op_sb(ops[0]),
        .reg_pc_write_en(pcw0), .reg_pc_read_en(pcr0), .reg_out_en(out0), .reg_write_en(wr0),
        .ram_addr_en(ae0), .ram_out_en(ro0), .ram_write_en(rw0),
        .instruction_done(dn0), .illegal(il0), .busy(bz0));
    bus_sequencer #(.REG_COUNT(8), .REG_SEL_W(3), .RAM_WAIT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v2), .instr_ready(rdy2), .reg_sel(reg_sel),
        .op_alu_reg(ops[6]), .op_alu_imm(ops[5]), .op_cpy(ops[4]), .op_cpypc(ops[3]),
        .op_jmp(ops[2]), .op_lb(ops[1]), .op_sb(ops[0]),
        .reg_pc_write_en(pcw2), .reg_pc_read_en(pcr2), .reg_out_en(out2), .reg_write_en(wr2),
        .ram_addr_en(ae2), .ram_out_en(ro2), .ram_write_en(rw2),
        .instruction_done(dn2), .illegal(il2), .busy(bz2));
    bus_sequencer #(.REG_COUNT(6), .REG_SEL_W(3), .RAM_WAIT(3)) u6 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v6), .instr_ready(rdy6), .reg_sel(reg_sel),
        .op_alu_reg(ops[6]), .op_alu_imm(ops[5]), .op_cpy(ops[4]), .op_cpypc(ops[3]),
        .op_jmp(ops[2]), .op_lb(ops[1]), .op_sb(ops[0]),
        .reg_pc_write_en(pcw6), .reg_pc_read_en(pcr6), .reg_out_en(out6), .reg_write_en(wr6),
        .ram_addr_en(ae6), .ram_out_en(ro6), .ram_write_en(rw6),
        .instruction_done(dn6), .illegal(il6), .busy(bz6));
    assign snap0 = {rdy0, pcw0, pcr0, out0, wr0, ae0, ro0, rw0, dn0, il0, bz0};
    assign snap2 = {rdy2, pcw2, pcr2, out2, wr2, ae2, ro2, rw2, dn2, il2, bz2};
    assign snap6 = {rdy6, pcw6, pcr6, 2'b00, out6, 2'b00, wr6, ae6, ro6, rw6, dn6, il6, bz6};
    function automatic logic [24:0] pack(input logic rdy, pcw, pcr, input logic [7:0] out, wr,
                                         input logic ae, ro, rw, dn, il, bz);
        return {rdy, pcw, pcr, out, wr, ae, ro, rw, dn, il, bz};
    endfunction
    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input logic [2:0] vmask, input logic [6:0] op, input logic [2:0] sel);
        @(negedge clk);
        {v6, v2, v0} = vmask;
        ops = op;
        reg_sel = sel;
        @(posedge clk);
        #1;
    endtask
    // At most one bus driver and one register capture in every cycle, all configurations.
    always @(negedge clk) begin
        check("excl0", 25'(($countones({out0, pcr0, ro0}) <= 1) && ($countones(wr0) <= 1)), 25'd1);
        check("excl2", 25'(($countones({out2, pcr2, ro2}) <= 1) && ($countones(wr2) <= 1)), 25'd1);
        check("excl6", 25'(($countones({out6, pcr6, ro6}) <= 1) && ($countones(wr6) <= 1)), 25'd1);
    end
    initial begin
        #12;
        check("rst0", snap0, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        check("rst6", snap6, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b001, ADD, 3'd5);
        check("b2b_add", snap0, pack(1, 0, 0, 8'h20, 8'h01, 0, 0, 0, 1, 0, 0));
        step(3'b001, CPY, 3'd3);
        check("b2b_cpy", snap0, pack(1, 0, 0, 8'h01, 8'h08, 0, 0, 0, 1, 0, 0));
        step(3'b001, CPC, 3'd7);
        check("b2b_cpypc", snap0, pack(1, 0, 1, 8'h00, 8'h80, 0, 0, 0, 1, 0, 0));
        step(3'b000, NOP, 3'd0);
        check("b2b_idle", snap0, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(3'b010, LB, 3'd4);
        check("lb_addr", snap2, pack(0, 0, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
        step(3'b000, SB, 3'd1);
        check("lb_wait1", snap2, pack(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
        step(3'b000, NOP, 3'd0);
        check("lb_wait2", snap2, pack(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
        step(3'b000, NOP, 3'd0);
        check("lb_data", snap2, pack(1, 0, 0, 8'h00, 8'h10, 0, 1, 0, 1, 0, 1));
        step(3'b000, NOP, 3'd0);
        check("lb_idle", snap2, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(3'b001, SB, 3'd6);
        check("sb_addr", snap0, pack(0, 0, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
        step(3'b001, CPY, 3'd2);
        check("sb_data", snap0, pack(1, 0, 0, 8'h40, 8'h00, 0, 0, 1, 1, 0, 1));
        step(3'b000, NOP, 3'd0);
        check("sb_idle", snap0, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(3'b001, ADD | LB, 3'd1);
        check("ill_multi", snap0, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0));
        step(3'b001, NOP, 3'd0);
        check("ill_none", snap0, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0));
        step(3'b100, CPY, 3'd7);
        check("ill_sel", snap6, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0));
        step(3'b100, CPY, 3'd5);
        check("cpy_top6", snap6, pack(1, 0, 0, 8'h01, 8'h20, 0, 0, 0, 1, 0, 0));
        step(3'b100, JMP, 3'd7);
        check("jmp_nosel6", snap6, pack(1, 1, 0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 0));
        step(3'b001, JMP, 3'd0);
        check("jmp", snap0, pack(1, 1, 0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 0));
        step(3'b001, LB, 3'd3);
        check("jmp_lb_addr", snap0, pack(0, 0, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
        step(3'b000, NOP, 3'd0);
        check("jmp_lb_data", snap0, pack(1, 0, 0, 8'h00, 8'h08, 0, 1, 0, 1, 0, 1));
        step(3'b100, LB, 3'd2);
        check("rl_addr", snap6, pack(0, 0, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
        step(3'b000, NOP, 3'd0);
        check("rl_wait", snap6, pack(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        check("rl_async", snap6, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b000, NOP, 3'd0);
        check("rl_idle", snap6, pack(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
        step(3'b100, IMM, 3'd7);
        check("rl_imm", snap6, pack(1, 0, 0, 8'h00, 8'h01, 0, 0, 0, 1, 0, 0));
        step(3'b000, NOP, 3'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
